// File: rtl/hybrid_bus_sequencer.sv
// Sequences single-word Avalon-conduit requests from the hybrid CPU onto the chipset CPU bus,
// handling req/grant arbitration, clk7_en-aligned strobes, longword bus locking and timeouts.
module hybrid_bus_sequencer #(
   parameter int ACK_TIMEOUT  = 4096,
   parameter int LOCK_TIMEOUT = 64,
   parameter int TCNT_W       = 13
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk7_en,
   input  logic        hyb_request,
   input  logic        hyb_read,
   input  logic        hyb_write,
   input  logic [22:0] hyb_address,
   input  logic [1:0]  hyb_byteenable,
   input  logic [15:0] hyb_writedata,
   input  logic        hyb_longword,
   output logic [15:0] hyb_readdata,
   output logic        hyb_complete,
   output logic        bus_req,
   input  logic        bus_grant,
   output logic [22:0] bus_addr,
   output logic        bus_as,
   output logic        bus_uds,
   output logic        bus_lds,
   output logic        bus_rw,
   output logic [15:0] bus_dout,
   input  logic [15:0] bus_din,
   input  logic        bus_ack,
   output logic        bus_err,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, ARB, ACK, DONE, LOCK} state_t;

   localparam logic [TCNT_W-1:0] ACK_LAST  = TCNT_W'(ACK_TIMEOUT - 1);
   localparam logic [TCNT_W-1:0] LOCK_LAST = TCNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [TCNT_W-1:0] TCNT_MAX  = {TCNT_W{1'b1}};

   state_t            state;
   logic [22:0]       lat_addr;
   logic [1:0]        lat_be;
   logic [15:0]       lat_wdata;
   logic              lat_rw;
   logic              lat_long;
   logic              lock_flag;
   logic              lock_pend;
   logic [TCNT_W-1:0] tcnt;

   logic req_valid;
   logic latch_now;
   logic enter_ack;

   // A locked bus takes the second half straight to ACK on the next enable, without re-arbitrating
   always_comb begin
      req_valid = (hyb_read != hyb_write) && (hyb_byteenable != 2'b00);
      latch_now = hyb_request && ((state == IDLE) || ((state == LOCK) && !lock_pend));
      enter_ack = clk7_en && (((state == ARB) && bus_grant) || ((state == LOCK) && lock_pend));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         lat_addr     <= '0;
         lat_be       <= '0;
         lat_wdata    <= '0;
         lat_rw       <= 1'b0;
         lat_long     <= 1'b0;
         lock_flag    <= 1'b0;
         lock_pend    <= 1'b0;
         tcnt         <= '0;
         hyb_readdata <= 16'hFFFF;
         hyb_complete <= 1'b0;
         bus_req      <= 1'b0;
         bus_addr     <= '0;
         bus_as       <= 1'b0;
         bus_uds      <= 1'b0;
         bus_lds      <= 1'b0;
         bus_rw       <= 1'b1;
         bus_dout     <= '0;
         bus_err      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         hyb_complete <= 1'b0;
         bus_err      <= 1'b0;

         if (latch_now) begin
            lat_addr  <= hyb_address;
            lat_be    <= hyb_byteenable;
            lat_wdata <= hyb_writedata;
            lat_rw    <= hyb_read;
            lat_long  <= hyb_longword && req_valid && (state == IDLE);
         end

         if (enter_ack) begin
            bus_addr  <= lat_addr;
            bus_rw    <= lat_rw;
            bus_dout  <= lat_wdata;
            bus_as    <= 1'b1;
            bus_uds   <= lat_be[1];
            bus_lds   <= lat_be[0];
            state     <= ACK;
            tcnt      <= '0;
            lock_pend <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (hyb_request) begin
                  tcnt <= '0;
                  busy <= 1'b1;
                  if (req_valid) begin
                     state   <= ARB;
                     bus_req <= 1'b1;
                  end else begin
                     state        <= DONE;
                     hyb_readdata <= 16'hFFFF;
                  end
               end
            end
            ARB: begin
            end
            ACK: begin
               if (clk7_en && bus_ack) begin
                  if (lat_rw) hyb_readdata <= bus_din;
                  bus_as  <= 1'b0;
                  bus_uds <= 1'b0;
                  bus_lds <= 1'b0;
                  state   <= DONE;
                  tcnt    <= '0;
               end else if (tcnt == ACK_LAST) begin
                  bus_as       <= 1'b0;
                  bus_uds      <= 1'b0;
                  bus_lds      <= 1'b0;
                  hyb_readdata <= 16'hFFFF;
                  bus_err      <= 1'b1;
                  state        <= DONE;
                  tcnt         <= '0;
               end else if (tcnt != TCNT_MAX) begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            DONE: begin
               hyb_complete <= 1'b1;
               tcnt         <= '0;
               if (lat_long && !lock_flag) begin
                  lock_flag <= 1'b1;
                  state     <= LOCK;
               end else begin
                  lock_flag <= 1'b0;
                  bus_req   <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            LOCK: begin
               // Once the second half is pending, the lock timer is frozen until ACK is entered
               if (!lock_pend) begin
                  if (hyb_request) begin
                     tcnt <= '0;
                     if (req_valid) begin
                        lock_pend <= 1'b1;
                     end else begin
                        state        <= DONE;
                        hyb_readdata <= 16'hFFFF;
                     end
                  end else if (tcnt == LOCK_LAST) begin
                     state     <= IDLE;
                     bus_req   <= 1'b0;
                     lock_flag <= 1'b0;
                     busy      <= 1'b0;
                     tcnt      <= '0;
                  end else if (tcnt != TCNT_MAX) begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hybrid_bus_sequencer.sv
// Directed bench for hybrid_bus_sequencer: a table of single-word transactions followed by
// hand-written sequences for enable pacing, grant stalls, timeouts, longword locks and reset.
module tb_hybrid_bus_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk7_en;
   logic        hyb_request;
   logic        hyb_read;
   logic        hyb_write;
   logic [22:0] hyb_address;
   logic [1:0]  hyb_byteenable;
   logic [15:0] hyb_writedata;
   logic        hyb_longword;
   logic [15:0] hyb_readdata;
   logic        hyb_complete;
   logic        bus_req;
   logic        bus_grant;
   logic [22:0] bus_addr;
   logic        bus_as;
   logic        bus_uds;
   logic        bus_lds;
   logic        bus_rw;
   logic [15:0] bus_dout;
   logic [15:0] bus_din;
   logic        bus_ack;
   logic        bus_err;
   logic        busy;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic div4  = 1'b0;
   logic en_at_edge;
   logic as_before;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [22:0] addr;
      logic [1:0]  be;
      logic [15:0] wdata;
      logic [15:0] din;
      logic [15:0] exp_rdata;
      logic        exp_as;
      logic        exp_uds;
      logic        exp_lds;
      logic        exp_rw;
      int          exp_lat;
   } vec_t;

   vec_t vecs[8];

   hybrid_bus_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .clk7_en        (clk7_en),
      .hyb_request    (hyb_request),
      .hyb_read       (hyb_read),
      .hyb_write      (hyb_write),
      .hyb_address    (hyb_address),
      .hyb_byteenable (hyb_byteenable),
      .hyb_writedata  (hyb_writedata),
      .hyb_longword   (hyb_longword),
      .hyb_readdata   (hyb_readdata),
      .hyb_complete   (hyb_complete),
      .bus_req        (bus_req),
      .bus_grant      (bus_grant),
      .bus_addr       (bus_addr),
      .bus_as         (bus_as),
      .bus_uds        (bus_uds),
      .bus_lds        (bus_lds),
      .bus_rw         (bus_rw),
      .bus_dout       (bus_dout),
      .bus_din        (bus_din),
      .bus_ack        (bus_ack),
      .bus_err        (bus_err),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] simulation time limit");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Outputs are sampled 1 time unit after each rising edge; in div4 mode clk7_en is high every 4th edge
   task automatic tick();
      en_at_edge = clk7_en;
      as_before  = bus_as;
      @(posedge clk);
      #1;
      cyc++;
      if (div4) clk7_en = ((cyc % 4) == 0);
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [22:0] addr, input logic [1:0] be,
                        input logic [15:0] wdata, input logic lw);
      hyb_read       = rd;
      hyb_write      = wr;
      hyb_address    = addr;
      hyb_byteenable = be;
      hyb_writedata  = wdata;
      hyb_longword   = lw;
      hyb_request    = 1'b1;
      tick();
      hyb_request    = 1'b0;
      hyb_longword   = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      int          n;
      logic        got;
      logic        saw;
      logic        s_uds;
      logic        s_lds;
      logic        s_rw;
      logic [22:0] s_addr;
      logic [15:0] s_dout;
      n = 0; got = 1'b0; saw = 1'b0;
      s_uds = 1'b0; s_lds = 1'b0; s_rw = 1'b0; s_addr = '0; s_dout = '0;
      bus_din = v.din;
      issue(v.rd, v.wr, v.addr, v.be, v.wdata, 1'b0);
      for (int k = 0; k < 20; k++) begin
         tick();
         n++;
         if (bus_as && !saw) begin
            saw = 1'b1; s_uds = bus_uds; s_lds = bus_lds; s_rw = bus_rw; s_addr = bus_addr; s_dout = bus_dout;
         end
         if (hyb_complete) begin
            got = 1'b1;
            break;
         end
      end
      checkOutput($sformatf("v%0d_complete_seen", idx), {31'b0, got}, 32'd1);
      checkOutput($sformatf("v%0d_latency", idx), n, v.exp_lat);
      checkOutput($sformatf("v%0d_rdata", idx), {16'b0, hyb_readdata}, {16'b0, v.exp_rdata});
      checkOutput($sformatf("v%0d_strobed", idx), {31'b0, saw}, {31'b0, v.exp_as});
      if (v.exp_as) begin
         checkOutput($sformatf("v%0d_uds", idx), {31'b0, s_uds}, {31'b0, v.exp_uds});
         checkOutput($sformatf("v%0d_lds", idx), {31'b0, s_lds}, {31'b0, v.exp_lds});
         checkOutput($sformatf("v%0d_rw", idx), {31'b0, s_rw}, {31'b0, v.exp_rw});
         checkOutput($sformatf("v%0d_addr", idx), {9'b0, s_addr}, {9'b0, v.addr});
         if (v.wr) checkOutput($sformatf("v%0d_dout", idx), {16'b0, s_dout}, {16'b0, v.wdata});
      end
      checkOutput($sformatf("v%0d_req_released", idx), {31'b0, bus_req}, 32'd0);
      checkOutput($sformatf("v%0d_busy_low", idx), {31'b0, busy}, 32'd0);
      tick();
      checkOutput($sformatf("v%0d_pulse_width", idx), {31'b0, hyb_complete}, 32'd0);
   endtask

   initial begin
      int   n;
      int   viol;
      int   pulses;
      int   enables;
      logic saw;

      vecs[0] = '{1'b1, 1'b0, 23'h0DFF0C, 2'b11, 16'h0000, 16'hA5C3, 16'hA5C3, 1'b1, 1'b1, 1'b1, 1'b1, 3};
      vecs[1] = '{1'b0, 1'b1, 23'h000123, 2'b01, 16'h1234, 16'hBEEF, 16'hA5C3, 1'b1, 1'b0, 1'b1, 1'b0, 3};
      vecs[2] = '{1'b1, 1'b0, 23'h7FFFFF, 2'b10, 16'h0000, 16'h00FF, 16'h00FF, 1'b1, 1'b1, 1'b0, 1'b1, 3};
      vecs[3] = '{1'b0, 1'b1, 23'h2AAAAA, 2'b10, 16'hCAFE, 16'h5555, 16'h00FF, 1'b1, 1'b1, 1'b0, 1'b0, 3};
      vecs[4] = '{1'b1, 1'b0, 23'h001000, 2'b00, 16'h0000, 16'h1357, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      vecs[5] = '{1'b1, 1'b1, 23'h001002, 2'b11, 16'h9999, 16'h2468, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      vecs[6] = '{1'b0, 1'b0, 23'h001004, 2'b11, 16'h0000, 16'h7777, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      vecs[7] = '{1'b1, 1'b0, 23'h000000, 2'b01, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 3};

      reset = 1'b1; clk7_en = 1'b1; hyb_request = 1'b0; hyb_read = 1'b0; hyb_write = 1'b0;
      hyb_address = '0; hyb_byteenable = '0; hyb_writedata = '0; hyb_longword = 1'b0;
      bus_grant = 1'b1; bus_din = '0; bus_ack = 1'b1;
      tick(); tick(); tick();
      checkOutput("reset_rdata", {16'b0, hyb_readdata}, 32'hFFFF);
      checkOutput("reset_rw", {31'b0, bus_rw}, 32'd1);
      checkOutput("reset_strobes", {29'b0, bus_as, bus_uds, bus_lds}, 32'd0);
      checkOutput("reset_misc", {28'b0, bus_req, hyb_complete, bus_err, busy}, 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i], i);
         tick();
      end

      // Byte write with clk7_en every 4th cycle; ack raised after two enables in ACK
      div4 = 1'b1; bus_ack = 1'b0; bus_din = 16'hDEAD;
      issue(1'b0, 1'b1, 23'h0ABCDE, 2'b01, 16'h1234, 1'b0);
      saw = 1'b0; enables = 0; pulses = 0;
      for (int k = 0; k < 80; k++) begin
         tick();
         if (bus_as != as_before) checkOutput("t2_strobe_on_en", {31'b0, en_at_edge}, 32'd1);
         if (bus_as && !saw) begin
            saw = 1'b1;
            checkOutput("t2_uds_lds", {30'b0, bus_uds, bus_lds}, 32'b01);
            checkOutput("t2_rw", {31'b0, bus_rw}, 32'd0);
            checkOutput("t2_dout", {16'b0, bus_dout}, 32'h1234);
         end
         if (as_before && bus_as && en_at_edge) begin
            enables++;
            if (enables == 2) bus_ack = 1'b1;
         end
         if (hyb_complete) begin
            pulses++;
            break;
         end
      end
      checkOutput("t2_complete", pulses, 1);
      checkOutput("t2_rdata_kept", {16'b0, hyb_readdata}, 32'h0000);
      div4 = 1'b0; clk7_en = 1'b1; bus_ack = 1'b1;
      tick(); tick();

      // Grant withheld for 20 cycles
      bus_grant = 1'b0; bus_din = 16'h3C3C;
      issue(1'b1, 1'b0, 23'h012345, 2'b11, 16'h0000, 1'b0);
      viol = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (!bus_req || bus_as || hyb_complete) viol++;
      end
      checkOutput("t3_stall_req_no_strobe", viol, 0);
      bus_grant = 1'b1;
      pulses = 0; saw = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (hyb_complete) pulses++;
         if (bus_as) saw = 1'b1;
      end
      checkOutput("t3_strobed_after_grant", {31'b0, saw}, 32'd1);
      checkOutput("t3_single_complete", pulses, 1);
      checkOutput("t3_rdata", {16'b0, hyb_readdata}, 32'h3C3C);

      // Ack never arrives: abort after ACK_TIMEOUT cycles in ACK
      bus_ack = 1'b0; bus_din = 16'h0F0F;
      issue(1'b1, 1'b0, 23'h055555, 2'b11, 16'h0000, 1'b0);
      n = 0;
      while (!bus_as && n < 5) begin tick(); n++; end
      checkOutput("t4_in_ack", {31'b0, bus_as}, 32'd1);
      n = 0;
      while (!bus_err && n < 5000) begin tick(); n++; end
      checkOutput("t4_timeout_cycles", n, 4096);
      checkOutput("t4_strobes_cleared", {29'b0, bus_as, bus_uds, bus_lds}, 32'd0);
      checkOutput("t4_rdata", {16'b0, hyb_readdata}, 32'hFFFF);
      tick();
      checkOutput("t4_complete_err", {30'b0, hyb_complete, bus_err}, 32'b10);
      checkOutput("t4_idle", {30'b0, busy, bus_req}, 32'd0);
      bus_ack = 1'b1;
      tick();

      // Longword read: the bus stays requested between halves and the second half ignores grant
      bus_din = 16'h1111;
      issue(1'b1, 1'b0, 23'h000200, 2'b11, 16'h0000, 1'b1);
      n = 0;
      while (!hyb_complete && n < 10) begin tick(); n++; end
      checkOutput("t5_first_latency", n, 3);
      checkOutput("t5_first_rdata", {16'b0, hyb_readdata}, 32'h1111);
      checkOutput("t5_locked_req", {30'b0, bus_req, busy}, 32'b11);
      viol = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (!bus_req) viol++;
      end
      checkOutput("t5_req_held", viol, 0);
      bus_grant = 1'b0; bus_din = 16'h2222;
      issue(1'b1, 1'b0, 23'h000201, 2'b11, 16'h0000, 1'b1);
      n = 0;
      while (!bus_as && n < 5) begin tick(); n++; end
      checkOutput("t5_skip_arb", n, 1);
      n = 0;
      while (!hyb_complete && n < 10) begin tick(); n++; end
      checkOutput("t5_second_latency", n, 2);
      checkOutput("t5_second_rdata", {16'b0, hyb_readdata}, 32'h2222);
      checkOutput("t5_unlocked", {30'b0, bus_req, busy}, 32'd0);
      bus_grant = 1'b1;
      tick();

      bus_din = 16'h4444;
      issue(1'b1, 1'b0, 23'h000300, 2'b11, 16'h0000, 1'b1);
      n = 0;
      while (!hyb_complete && n < 10) begin tick(); n++; end
      checkOutput("t5b_first_complete", {31'b0, hyb_complete}, 32'd1);
      n = 0;
      while (bus_req && n < 200) begin tick(); n++; end
      checkOutput("t5b_lock_timeout", n, 64);
      checkOutput("t5b_busy_low", {31'b0, busy}, 32'd0);
      tick();

      // Reset in the middle of ACK
      bus_ack = 1'b0;
      issue(1'b1, 1'b0, 23'h000400, 2'b11, 16'h0000, 1'b0);
      tick();
      checkOutput("t6_in_ack", {31'b0, bus_as}, 32'd1);
      tick();
      reset = 1'b1;
      tick();
      checkOutput("t6_reset_strobes", {29'b0, bus_as, bus_uds, bus_lds}, 32'd0);
      checkOutput("t6_reset_req", {30'b0, bus_req, busy}, 32'd0);
      checkOutput("t6_reset_rdata", {16'b0, hyb_readdata}, 32'hFFFF);
      reset = 1'b0; bus_ack = 1'b1;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (hyb_complete) pulses++;
      end
      checkOutput("t6_no_complete", pulses, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hybrid_bus_sequencer.md
Name: hybrid_bus_sequencer

Overview:
- Sequences word requests from the HPS hybrid-CPU Avalon conduit onto the internal chipset CPU bus.
- Arbitrates for chipset bus ownership via a req/grant pair.
- Converts byteenable into UDS/LDS strobes, aligns strobes and ack sampling to clk7_en, and returns a one-cycle complete pulse with read data.
- Supports longword locking (bus held between two word halves), with ack and lock timeouts.

Parameters:
ACK_TIMEOUT, 4096, clk cycles in ACK state without bus_ack before the cycle is aborted as a bus error
LOCK_TIMEOUT, 64, clk cycles the bus stays locked after the first longword half while waiting for the second request
TCNT_W, 13, counter width; must hold max(ACK_TIMEOUT, LOCK_TIMEOUT)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clk7_en  in  1  chipset clock enable
hyb_request  in  1  single-cycle request pulse from bridge
hyb_read  in  1  read qualifier, valid with request
hyb_write  in  1  write qualifier, valid with request
hyb_address  in  23  word address (byte address bits 23:1)
hyb_byteenable  in  2  [1]=upper byte (UDS), [0]=lower byte (LDS)
hyb_writedata  in  16  write data
hyb_longword  in  1  first half of a locked longword
hyb_readdata  out  16  read data, held until next completion
hyb_complete  out  1  one-cycle completion pulse
bus_req  out  1  chipset bus request
bus_grant  in  1  chipset bus grant
bus_addr  out  23  chipset word address
bus_as  out  1  address strobe, active high
bus_uds  out  1  upper data strobe, active high
bus_lds  out  1  lower data strobe, active high
bus_rw  out  1  1=read, 0=write
bus_dout  out  16  write data to chipset
bus_din  in  16  read data from chipset
bus_ack  in  1  data acknowledge, active high
bus_err  out  1  one-cycle pulse on ack timeout
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE, bus_rw=1, hyb_readdata=16'hFFFF, all other outputs 0, counters 0, lock flag cleared. Reset mid-cycle drops strobes and bus_req on the reset edge; no complete pulse is issued.
- IDLE: on hyb_request, latch address, byteenable, writedata, rw=hyb_read, longword.
  - Invalid request (read==write) or byteenable==0: go to DONE with hyb_readdata=FFFF, no bus activity.
  - Valid request: go to ARB.
- ARB: bus_req=1. Go to ACK on an edge where bus_grant && clk7_en.
  - On entry to ACK: bus_addr, bus_rw, bus_dout driven from latches; bus_as=1; bus_uds=be[1]; bus_lds=be[0].
- ACK:
  - On clk7_en && bus_ack: capture bus_din into hyb_readdata (reads only; writes leave it unchanged); clear strobes; go to DONE.
  - Ack counter increments every clk. On reaching ACK_TIMEOUT: clear strobes, hyb_readdata=FFFF, bus_err pulse, go to DONE.
  - bus_grant dropping in ACK is ignored; the grant is not revocable mid-cycle.
- DONE: hyb_complete=1 for exactly one cycle.
  - If latched longword=1 and lock flag=0: set lock flag, keep bus_req=1, go to LOCK.
  - Otherwise: clear lock flag, bus_req=0, go to IDLE.
- LOCK: bus_req stays 1. Lock counter increments every clk.
  - Valid hyb_request: latch as in IDLE and go straight to ACK on the next clk7_en, skipping ARB. The second request's longword bit is ignored; locks never chain.
  - On reaching LOCK_TIMEOUT: bus_req=0, clear lock flag, go to IDLE.
  - An invalid request in LOCK completes via DONE as in IDLE and ends the lock.
- hyb_request in ARB, ACK or DONE is ignored; exactly one outstanding transaction is allowed.
- Latency, with grant=1, clk7_en=1, ack=1 and request sampled at edge e0: ARB at e1, strobes high from e2, hyb_complete high for the cycle after e3, IDLE at e4.
- The counters saturate and never wrap. Both are cleared on every state entry.

Test Plan:
1. Read word, addr 23'h0DFF0C, be=11, grant/clk7_en/ack tied 1, bus_din=16'hA5C3 -> bus_uds=bus_lds=1, bus_rw=1; hyb_complete 3 cycles after request; hyb_readdata=A5C3; bus_req low after DONE.
2. Write byte, be=01, wdata=16'h1234, clk7_en every 4th cycle, ack after 2 enables -> bus_uds=0, bus_lds=1, bus_rw=0, bus_dout=1234; strobes change only on clk7_en edges; hyb_readdata unchanged.
3. Grant held low 20 cycles, then high -> bus_req high throughout, no strobes until the grant+clk7_en edge, single complete pulse.
4. Ack never asserted -> after 4096 cycles in ACK: bus_err pulse, hyb_complete pulse, hyb_readdata=FFFF, strobes low, IDLE.
5. Longword read: first request longword=1, second request 10 cycles later -> bus_req stays 1 between halves, second cycle skips ARB, two complete pulses. Repeat with the second request absent: bus_req drops at 64 cycles.
6. be=00 request, then read&&write=1 request, then reset asserted mid-ACK -> first two complete in DONE with FFFF and no strobes; reset clears strobes and bus_req on the reset edge, with no complete pulse.
